// File: rtl/row_store_responder.sv
`default_nettype none
// ============================================================================
// row_store_responder : single-port 16-bit word store with read/write/refresh
//                       handshake initiators and a one-cycle HOLD between ops.
// Revision 1.0 : initial release
// ============================================================================
module row_store_responder #(
  parameter int ADDR_BITS      = 15,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [23:0] readAddress,
  output logic        readAcknowledge,
  output logic [15:0] readData,
  input  logic        write,
  input  logic [23:0] writeAddress,
  input  logic [15:0] writeData,
  output logic        writeAcknowledge,
  input  logic        refresh,
  output logic        refreshAcknowledge,
  output logic        busy
);

  localparam int C_CW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int C_DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_READ_DATA = 2'd1,
    S_REFRESH   = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [C_CW-1:0]   r_count, w_count_nxt;
  logic              r_rd_ack, r_wr_ack, r_rf_ack, r_busy;
  logic              w_rd_ack_nxt, w_wr_ack_nxt, w_rf_ack_nxt, w_busy_nxt;
  logic              w_mem_we, w_mem_re;
  logic [15:0]       r_rd_data, r_rd_word;
  logic [15:0]       r_mem [0:C_DEPTH-1];

  logic [ADDR_BITS-1:0] w_waddr, w_raddr;
  assign w_waddr = writeAddress[ADDR_BITS-1:0];
  assign w_raddr = readAddress[ADDR_BITS-1:0];

  // Upper address bits alias silently onto the implemented depth.
  if (ADDR_BITS < 24) begin : g_addr_alias
    logic w_unused_hi;
    assign w_unused_hi = ^{readAddress[23:ADDR_BITS], writeAddress[23:ADDR_BITS]};
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_rd_ack_nxt = 1'b0;
    w_wr_ack_nxt = 1'b0;
    w_rf_ack_nxt = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (refresh) begin
          w_state_nxt = S_REFRESH;
          w_count_nxt = C_CW'(REFRESH_CYCLES - 1);
        end else if (write) begin
          w_mem_we     = 1'b1;
          w_wr_ack_nxt = 1'b1;
          w_state_nxt  = S_HOLD;
        end else if (read) begin
          w_mem_re    = 1'b1;
          w_state_nxt = S_READ_DATA;
        end
      end
      S_READ_DATA: begin
        w_rd_ack_nxt = 1'b1;
        w_state_nxt  = S_HOLD;
      end
      S_REFRESH: begin
        if (r_count == '0) begin
          w_rf_ack_nxt = 1'b1;
          w_state_nxt  = S_HOLD;
        end else begin
          w_count_nxt = r_count - C_CW'(1);
        end
      end
      S_HOLD: begin
        // Gives the initiator one edge to present its post-ack address/data.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_rd_ack  <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rf_ack  <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_data <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_rd_ack <= w_rd_ack_nxt;
      r_wr_ack <= w_wr_ack_nxt;
      r_rf_ack <= w_rf_ack_nxt;
      r_busy   <= w_busy_nxt;
      if (w_rd_ack_nxt) begin
        r_rd_data <= r_rd_word;
      end
    end
  end

  // Storage is never cleared; reset only blocks new accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_mem_we) begin
        r_mem[w_waddr] <= writeData;
      end
      if (w_mem_re) begin
        r_rd_word <= r_mem[w_raddr];
      end
    end
  end

  assign readAcknowledge    = r_rd_ack;
  assign writeAcknowledge   = r_wr_ack;
  assign refreshAcknowledge = r_rf_ack;
  assign busy               = r_busy;
  assign readData           = r_rd_data;

endmodule
`default_nettype wire
